fb_draw_ctrl: RTL and testbench

FB_DRAW_CTRL -- requirements
Module: fb_draw_ctrl

---
 rtl/fb_draw_ctrl.sv | 141 ++++++++++++++
 tb/tb_fb_draw_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_draw_ctrl.sv
// fb_draw_ctrl: merges CPU single-pixel writes and clipped rectangle fills onto one framebuffer write port.
// Latency: an accepted CPU pixel appears on the draw port the next cycle; fill pixels stream one per free cycle.
// Backpressure: CPU pixels always win the port; fill counters stall in any cycle a CPU pixel is accepted.
module fb_draw_ctrl #(
  parameter int FB_WIDTH  = 160,
  parameter int FB_HEIGHT = 120
) (
  input  logic        Fast_Clock,
  input  logic        Reset,
  input  logic        Pix_Req,
  input  logic [31:0] Pix_X,
  input  logic [31:0] Pix_Y,
  input  logic [31:0] Pix_Color,
  output logic        Pix_Ack,
  input  logic        Fill_Start,
  input  logic [7:0]  Fill_X0,
  input  logic [6:0]  Fill_Y0,
  input  logic [7:0]  Fill_W,
  input  logic [6:0]  Fill_H,
  input  logic [8:0]  Fill_Color,
  output logic        Fill_Busy,
  output logic        Fill_Done,
  output logic        Enable_Draw,
  output logic [31:0] Draw_X,
  output logic [31:0] Draw_Y,
  output logic [31:0] Draw_Color
);

  localparam logic [8:0] FB_W9 = 9'(FB_WIDTH);
  localparam logic [8:0] FB_H9 = 9'(FB_HEIGHT);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t     state;
  logic [8:0] x0;
  logic [8:0] x_end;
  logic [8:0] y_end;
  logic [8:0] cur_x;
  logic [8:0] cur_y;
  logic [8:0] fill_color;

  logic [8:0] sum_x;
  logic [8:0] sum_y;
  logic [8:0] start_x_end;
  logic [8:0] start_y_end;
  logic       start_empty;
  logic       cpu_accept;
  logic       last_pix;
  logic       row_end;

  // Only the low 9 color bits reach the framebuffer; the rest is intentionally dropped.
  logic unused_pix_color;
  assign unused_pix_color = ^Pix_Color[31:9];

  // Clip the requested rectangle to the framebuffer in 9 bits so origin+size cannot wrap.
  always_comb begin
    sum_x       = {1'b0, Fill_X0} + {1'b0, Fill_W};
    sum_y       = {2'b0, Fill_Y0} + {2'b0, Fill_H};
    start_x_end = ((sum_x < FB_W9) ? sum_x : FB_W9) - 9'd1;
    start_y_end = ((sum_y < FB_H9) ? sum_y : FB_H9) - 9'd1;
    start_empty = (Fill_W == 8'd0) || (Fill_H == 7'd0) ||
                  ({1'b0, Fill_X0} >= FB_W9) || ({2'b0, Fill_Y0} >= FB_H9);
    cpu_accept  = Pix_Req && !Pix_Ack;
    row_end     = (cur_x == x_end);
    last_pix    = row_end && (cur_y == y_end);
  end

  // Fill FSM, CPU arbitration and registered draw port in one sequential block.
  always_ff @(posedge Fast_Clock) begin
    if (!Reset) begin
      state       <= IDLE;
      x0          <= '0;
      x_end       <= '0;
      y_end       <= '0;
      cur_x       <= '0;
      cur_y       <= '0;
      fill_color  <= '0;
      Pix_Ack     <= 1'b0;
      Fill_Busy   <= 1'b0;
      Fill_Done   <= 1'b0;
      Enable_Draw <= 1'b0;
      Draw_X      <= '0;
      Draw_Y      <= '0;
      Draw_Color  <= '0;
    end else begin
      Enable_Draw <= 1'b0;
      Pix_Ack     <= 1'b0;
      Fill_Done   <= 1'b0;

      // A CPU pixel claims the port; the fill branch below yields in that cycle.
      if (cpu_accept) begin
        Enable_Draw <= 1'b1;
        Pix_Ack     <= 1'b1;
        Draw_X      <= Pix_X;
        Draw_Y      <= Pix_Y;
        Draw_Color  <= {23'd0, Pix_Color[8:0]};
      end

      case (state)
        IDLE: begin
          if (Fill_Start) begin
            x0         <= {1'b0, Fill_X0};
            x_end      <= start_x_end;
            y_end      <= start_y_end;
            cur_x      <= {1'b0, Fill_X0};
            cur_y      <= {2'b0, Fill_Y0};
            fill_color <= Fill_Color;
            Fill_Busy  <= 1'b1;
            state      <= start_empty ? DONE : FILL;
          end
        end
        FILL: begin
          if (!cpu_accept) begin
            Enable_Draw <= 1'b1;
            Draw_X      <= {23'd0, cur_x};
            Draw_Y      <= {23'd0, cur_y};
            Draw_Color  <= {23'd0, fill_color};
            if (last_pix) begin
              state <= DONE;
            end else if (row_end) begin
              cur_x <= x0;
              cur_y <= cur_y + 9'd1;
            end else begin
              cur_x <= cur_x + 9'd1;
            end
          end
        end
        DONE: begin
          Fill_Done <= 1'b1;
          Fill_Busy <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          Fill_Busy <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fb_draw_ctrl.sv
// tb_fb_draw_ctrl: queue-based reference model compared every cycle, plus directed literal pixel checks.
// Latency: model expects CPU pixel one cycle after acceptance, fill pixels in every non-CPU cycle.
// Backpressure: CPU requests are held until Pix_Ack, as a real CPU would.
module tb_fb_draw_ctrl;

  localparam int FB_WIDTH  = 160;
  localparam int FB_HEIGHT = 120;

  logic        Fast_Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        Pix_Req = 1'b0;
  logic [31:0] Pix_X = '0;
  logic [31:0] Pix_Y = '0;
  logic [31:0] Pix_Color = '0;
  logic        Pix_Ack;
  logic        Fill_Start = 1'b0;
  logic [7:0]  Fill_X0 = '0;
  logic [6:0]  Fill_Y0 = '0;
  logic [7:0]  Fill_W = '0;
  logic [6:0]  Fill_H = '0;
  logic [8:0]  Fill_Color = '0;
  logic        Fill_Busy;
  logic        Fill_Done;
  logic        Enable_Draw;
  logic [31:0] Draw_X;
  logic [31:0] Draw_Y;
  logic [31:0] Draw_Color;

  fb_draw_ctrl #(.FB_WIDTH(FB_WIDTH), .FB_HEIGHT(FB_HEIGHT)) dut (
    .Fast_Clock (Fast_Clock),
    .Reset      (Reset),
    .Pix_Req    (Pix_Req),
    .Pix_X      (Pix_X),
    .Pix_Y      (Pix_Y),
    .Pix_Color  (Pix_Color),
    .Pix_Ack    (Pix_Ack),
    .Fill_Start (Fill_Start),
    .Fill_X0    (Fill_X0),
    .Fill_Y0    (Fill_Y0),
    .Fill_W     (Fill_W),
    .Fill_H     (Fill_H),
    .Fill_Color (Fill_Color),
    .Fill_Busy  (Fill_Busy),
    .Fill_Done  (Fill_Done),
    .Enable_Draw(Enable_Draw),
    .Draw_X     (Draw_X),
    .Draw_Y     (Draw_Y),
    .Draw_Color (Draw_Color)
  );

  always #5 Fast_Clock = ~Fast_Clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference model: a fill is a list of clipped pixels; CPU pixels preempt it.
  typedef struct { int x; int y; } xy_t;
  typedef struct { int cyc; logic [31:0] x; logic [31:0] y; logic [31:0] c; } wr_t;

  xy_t         fill_q[$];
  wr_t         wlog[$];
  int          cyc = 0;
  int          phase = 0;          // 0 idle, 1 pixels outstanding, 2 completion pending
  int          m_start_cyc = -1;
  int          done_cyc = -1;
  bit          m_valid = 0;
  bit          m_acc;
  xy_t         m_px;
  logic [8:0]  m_color = '0;
  logic        e_en = 0, e_ack = 0, e_busy = 0, e_done = 0, e_draw_chk = 0;
  logic [31:0] e_x = '0, e_y = '0, e_c = '0;

  always @(posedge Fast_Clock) begin
    cyc++;
    m_valid = 1;
    if (!Reset) begin
      e_en = 0; e_ack = 0; e_busy = 0; e_done = 0;
      e_x = '0; e_y = '0; e_c = '0; e_draw_chk = 1;
      fill_q.delete();
      phase = 0;
    end else begin
      m_acc = Pix_Req && !e_ack;
      e_en = 0; e_ack = 0; e_done = 0; e_draw_chk = 0;
      if (m_acc) begin
        e_en = 1; e_ack = 1; e_draw_chk = 1;
        e_x = Pix_X; e_y = Pix_Y; e_c = {23'd0, Pix_Color[8:0]};
      end
      if (phase == 0) begin
        if (Fill_Start) begin
          for (int yy = int'(Fill_Y0); yy < int'(Fill_Y0) + int'(Fill_H) && yy < FB_HEIGHT; yy++)
            for (int xx = int'(Fill_X0); xx < int'(Fill_X0) + int'(Fill_W) && xx < FB_WIDTH; xx++)
              fill_q.push_back('{xx, yy});
          m_color = Fill_Color;
          e_busy = 1;
          m_start_cyc = cyc;
          phase = (fill_q.size() > 0) ? 1 : 2;
        end
      end else if (phase == 1) begin
        if (!m_acc) begin
          m_px = fill_q.pop_front();
          e_en = 1; e_draw_chk = 1;
          e_x = m_px.x; e_y = m_px.y; e_c = {23'd0, m_color};
          if (fill_q.size() == 0) phase = 2;
        end
      end else begin
        e_done = 1; e_busy = 0; phase = 0;
      end
    end
  end

  // Compare every cycle away from the active edge and log DUT writes for directed checks.
  always @(negedge Fast_Clock) begin
    if (m_valid) begin
      chk("enable_draw", Enable_Draw, e_en);
      chk("pix_ack", Pix_Ack, e_ack);
      chk("fill_busy", Fill_Busy, e_busy);
      chk("fill_done", Fill_Done, e_done);
      if (e_draw_chk) begin
        chk("draw_x", Draw_X, e_x);
        chk("draw_y", Draw_Y, e_y);
        chk("draw_color", Draw_Color, e_c);
      end
      if (Enable_Draw) wlog.push_back('{cyc, Draw_X, Draw_Y, Draw_Color});
      if (Fill_Done && done_cyc < 0) done_cyc = cyc;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge Fast_Clock);
    #1;
  endtask

  task automatic clear_log();
    wlog.delete();
    done_cyc = -1;
  endtask

  task automatic start_fill(input int x0, input int y0, input int w, input int h, input int c);
    Fill_X0 = 8'(x0); Fill_Y0 = 7'(y0); Fill_W = 8'(w); Fill_H = 7'(h); Fill_Color = 9'(c);
    Fill_Start = 1'b1;
    tick(1);
    Fill_Start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit);
    int k = 0;
    while (done_cyc < 0 && k < limit) begin
      tick(1);
      k++;
    end
    chk({name, "_done_seen"}, 32'(done_cyc >= 0), 32'd1);
    tick(2);
  endtask

  task automatic cpu_pixel(input logic [31:0] x, input logic [31:0] y, input logic [31:0] c);
    int k = 0;
    Pix_X = x; Pix_Y = y; Pix_Color = c; Pix_Req = 1'b1;
    while (!Pix_Ack && k < 20) begin
      tick(1);
      k++;
    end
    chk("cpu_ack_seen", 32'(Pix_Ack), 32'd1);
    Pix_Req = 1'b0;
    tick(1);
  endtask

  task automatic check_px(input string name, input int i, input int ex, input int ey, input int ec);
    if (i >= wlog.size()) begin
      chk({name, "_present"}, 32'(wlog.size()), 32'(i + 1));
    end else begin
      chk({name, "_x"}, wlog[i].x, 32'(ex));
      chk({name, "_y"}, wlog[i].y, 32'(ey));
      chk({name, "_c"}, wlog[i].c, 32'(ec));
    end
  endtask

  task automatic check_cyc(input string name, input int i, input int ecyc);
    if (i < wlog.size()) chk(name, 32'(wlog[i].cyc), 32'(ecyc));
    else chk({name, "_present"}, 32'(wlog.size()), 32'(i + 1));
  endtask

  initial begin
    int fill_seen;

    // Reset state
    tick(2);
    chk("rst_enable_draw", 32'(Enable_Draw), 0);
    chk("rst_pix_ack", 32'(Pix_Ack), 0);
    chk("rst_fill_busy", 32'(Fill_Busy), 0);
    chk("rst_fill_done", 32'(Fill_Done), 0);
    chk("rst_draw_x", Draw_X, 0);
    chk("rst_draw_color", Draw_Color, 0);
    Reset = 1'b1;
    tick(2);

    // 3x2 fill: six consecutive writes then Fill_Done
    clear_log();
    start_fill(10, 20, 3, 2, 'h1C0);
    wait_done("r31", 40);
    chk("r31_count", 32'(wlog.size()), 6);
    check_px("r31_p0", 0, 10, 20, 'h1C0);
    check_px("r31_p1", 1, 11, 20, 'h1C0);
    check_px("r31_p2", 2, 12, 20, 'h1C0);
    check_px("r31_p3", 3, 10, 21, 'h1C0);
    check_px("r31_p4", 4, 11, 21, 'h1C0);
    check_px("r31_p5", 5, 12, 21, 'h1C0);
    for (int i = 0; i < 6; i++) check_cyc("r31_cyc", i, m_start_cyc + 1 + i);
    chk("r31_done_cyc", 32'(done_cyc), 32'(m_start_cyc + 7));

    // Corner fill clipped to 2x2
    clear_log();
    start_fill(158, 118, 8, 8, 'h007);
    wait_done("r32", 40);
    chk("r32_count", 32'(wlog.size()), 4);
    check_px("r32_p0", 0, 158, 118, 'h007);
    check_px("r32_p1", 1, 159, 118, 'h007);
    check_px("r32_p2", 2, 158, 119, 'h007);
    check_px("r32_p3", 3, 159, 119, 'h007);

    // Zero-width and off-screen fills: no writes, done one cycle after start
    clear_log();
    start_fill(5, 5, 0, 4, 'h0FF);
    wait_done("r33", 10);
    chk("r33_count", 32'(wlog.size()), 0);
    chk("r33_done_cyc", 32'(done_cyc), 32'(m_start_cyc + 1));
    clear_log();
    start_fill(200, 5, 4, 4, 'h0FF);
    wait_done("r17", 10);
    chk("r17_count", 32'(wlog.size()), 0);

    // CPU pixel held high across a 4x1 fill: strict alternation
    clear_log();
    Pix_X = 5; Pix_Y = 7; Pix_Color = 'h38; Pix_Req = 1'b1;
    start_fill(20, 30, 4, 1, 'h1FF);
    wait_done("r34", 40);
    Pix_Req = 1'b0;
    tick(2);
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) check_px("r34_cpu", i, 5, 7, 'h38);
      else check_px("r34_fill", i, 20 + i / 2, 30, 'h1FF);
      check_cyc("r34_cyc", i, m_start_cyc + i);
    end
    fill_seen = 0;
    foreach (wlog[i]) if (wlog[i].c == 32'h1FF) fill_seen++;
    chk("r34_fill_count", 32'(fill_seen), 4);

    // CPU pixel passed through unclipped, color truncated to 9 bits
    clear_log();
    cpu_pixel(32'd1000, 32'hFFFF_0000, 32'h0000_0FFF);
    check_px("r26_cpu", 0, 1000, 32'hFFFF_0000, 'h1FF);
    chk("r26_count", 32'(wlog.size()), 1);

    // Reset in the third write cycle of a 4x4 fill
    clear_log();
    start_fill(30, 40, 4, 4, 'h055);
    repeat (3) @(negedge Fast_Clock);
    #1;
    Reset = 1'b0;
    tick(1);
    chk("r35_en", 32'(Enable_Draw), 0);
    chk("r35_busy", 32'(Fill_Busy), 0);
    chk("r35_done", 32'(Fill_Done), 0);
    chk("r35_x", Draw_X, 0);
    chk("r35_y", Draw_Y, 0);
    chk("r35_c", Draw_Color, 0);
    chk("r35_writes", 32'(wlog.size()), 3);
    Reset = 1'b1;
    tick(10);
    chk("r35_no_done", 32'(done_cyc), 32'hFFFF_FFFF);
    clear_log();
    start_fill(0, 0, 2, 2, 'h0AA);
    wait_done("r35_new", 20);
    chk("r35_new_count", 32'(wlog.size()), 4);
    check_px("r35_new_p3", 3, 1, 1, 'h0AA);

    // Pending CPU request during reset is accepted after release
    clear_log();
    Reset = 1'b0;
    Pix_X = 3; Pix_Y = 4; Pix_Color = 'h123; Pix_Req = 1'b1;
    tick(2);
    chk("r30_held_en", 32'(Enable_Draw), 0);
    Reset = 1'b1;
    cpu_pixel(3, 4, 'h123);
    check_px("r30_cpu", 0, 3, 4, 'h123);

    // Fill_Start mid-fill is ignored
    clear_log();
    start_fill(40, 50, 3, 2, 'h111);
    tick(1);
    start_fill(0, 0, 5, 5, 'h0F0);
    wait_done("r36", 40);
    chk("r36_count", 32'(wlog.size()), 6);
    check_px("r36_p0", 0, 40, 50, 'h111);
    check_px("r36_p2", 2, 42, 50, 'h111);
    check_px("r36_p5", 5, 42, 51, 'h111);
    chk("r36_done_cyc", 32'(done_cyc), 32'(m_start_cyc + 7));

    // Full-screen fill
    clear_log();
    start_fill(0, 0, 160, 120, 'h1A5);
    wait_done("r28", 20000);
    chk("r28_count", 32'(wlog.size()), 19200);
    if (wlog.size() > 0) begin
      chk("r28_span", 32'(wlog[wlog.size()-1].cyc - wlog[0].cyc), 19199);
      chk("r28_done_cyc", 32'(done_cyc), 32'(wlog[wlog.size()-1].cyc + 1));
      check_px("r28_last", wlog.size() - 1, 159, 119, 'h1A5);
    end else begin
      chk("r28_nonempty", 32'(wlog.size()), 19200);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
